// File: rtl/psum_drain.sv
// Resolves a column's carry-save partial-sum pair with a carry-propagate add and
// buffers the results in a credit-controlled FWFT FIFO. Optional: PSUM_DRAIN_ACCUM_EN.
`timescale 1ns/1ps

module psum_drain #(
    parameter int ARRAYSIZE = 4,
    parameter int BUSW      = ARRAYSIZE + 16,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [BUSW-1:0]            psum0,
    input  logic [BUSW-1:0]            psum1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BUSW-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LW:0] DEPTH_C = (LW + 1)'(DEPTH);

    // Carry-propagate resolve; the carry above the top bit is dropped on purpose.
    function automatic logic [BUSW-1:0] cpa(input logic [BUSW-1:0] a, input logic [BUSW-1:0] b);
        return a + b;
    endfunction

    logic                 stg_valid_q, stg_valid_d;
    logic [BUSW-1:0]      stg_p0_q, stg_p0_d;
    logic [BUSW-1:0]      stg_p1_q, stg_p1_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [BUSW-1:0]      mem_q [DEPTH];
    logic [BUSW-1:0]      mem_d [DEPTH];

    logic [LW:0]          credit_s;
    logic                 accept_s;
    logic                 pop_s;
    logic                 wr_en_s;
    logic [BUSW-1:0]      sum_s;
    logic [BUSW-1:0]      wr_data_s;

`ifdef PSUM_DRAIN_ACCUM_EN
    logic                 stg_last_q, stg_last_d;
    logic [BUSW-1:0]      acc_q, acc_d;
`else
    logic                 unused_last_s;
    assign unused_last_s = in_last;
`endif

    // Credit check uses registered state only, so in_ready never sees out_ready.
    always_comb begin
        credit_s = {1'b0, level_q} + {{LW{1'b0}}, stg_valid_q};
        if (rst_n && (credit_s < DEPTH_C)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
        accept_s  = in_valid && in_ready;
        out_valid = (level_q != {LW{1'b0}});
        pop_s     = out_valid && out_ready;
        level     = level_q;
        if (out_valid) begin
            out_data = mem_q[rd_ptr_q];
        end else begin
            out_data = {BUSW{1'b0}};
        end
    end

    // Capture stage and resolve / optional accumulate.
    always_comb begin
        stg_valid_d = accept_s;
        if (accept_s) begin
            stg_p0_d = psum0;
            stg_p1_d = psum1;
        end else begin
            stg_p0_d = stg_p0_q;
            stg_p1_d = stg_p1_q;
        end
        sum_s = cpa(stg_p0_q, stg_p1_q);
`ifdef PSUM_DRAIN_ACCUM_EN
        if (accept_s) begin
            stg_last_d = in_last;
        end else begin
            stg_last_d = stg_last_q;
        end
        wr_data_s = cpa(acc_q, sum_s);
        wr_en_s   = stg_valid_q && stg_last_q;
        if (stg_valid_q && stg_last_q) begin
            acc_d = {BUSW{1'b0}};
        end else if (stg_valid_q) begin
            acc_d = wr_data_s;
        end else begin
            acc_d = acc_q;
        end
`else
        wr_data_s = sum_s;
        wr_en_s   = stg_valid_q;
`endif
    end

    // FIFO storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = wr_data_s;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid_q <= 1'b0;
            stg_p0_q    <= {BUSW{1'b0}};
            stg_p1_q    <= {BUSW{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {BUSW{1'b0}};
            end
`ifdef PSUM_DRAIN_ACCUM_EN
            stg_last_q  <= 1'b0;
            acc_q       <= {BUSW{1'b0}};
`endif
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_p0_q    <= stg_p0_d;
            stg_p1_q    <= stg_p1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            mem_q       <= mem_d;
`ifdef PSUM_DRAIN_ACCUM_EN
            stg_last_q  <= stg_last_d;
            acc_q       <= acc_d;
`endif
        end
    end

endmodule
